traffic_light_ctrl: RTL and testbench

Tick-driven two-road traffic light controller with a pedestrian walk request. It consumes the 1-cycle `tick` pulse from the tick divider and sequences North-South and East-West lamps through fixed phase durations counted in ticks. A pending pedestrian request lengthens the next all-red phase and asserts `walk` for that phase. It sits between the tick divider and the lamp/LED outputs in the traffic top level.

---
 rtl/traffic_pkg.sv | 25 ++
 rtl/traffic_light_ctrl.sv | 131 +++++++++++++
 tb/tb_traffic_light_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic light controller:
// state encoding and a compile-time helper for sizing the phase counter.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G = 3'd0,
      NS_Y = 3'd1,
      AR1  = 3'd2,
      EW_G = 3'd3,
      EW_Y = 3'd4,
      AR2  = 3'd5
   } state_t;

   // Largest of the four phase durations, used to size the tick counter.
   function automatic int unsigned max_dur(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/traffic_light_ctrl.sv
// Tick-driven NS/EW traffic light sequencer with a pedestrian walk request
// that stretches the next all-red phase and lights the walk lamp during it.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_TICKS  = 32'd5,
   parameter int unsigned YELLOW_TICKS = 32'd2,
   parameter int unsigned ALLRED_TICKS = 32'd1,
   parameter int unsigned PED_TICKS    = 32'd3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       ped_req,
   output logic       ns_g,
   output logic       ns_y,
   output logic       ns_r,
   output logic       ew_g,
   output logic       ew_y,
   output logic       ew_r,
   output logic       walk,
   output logic [2:0] phase
);

   localparam int unsigned MAX_DUR = max_dur(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS, PED_TICKS);
   localparam int          CNT_W   = (MAX_DUR > 32'd1) ? $clog2(MAX_DUR) : 1;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] dur_m1_s;
   logic             ped_pend_r;
   logic             walk_r;
   logic             last_tick_s;
   logic             enter_ar_s;
   logic             leave_ar_s;
   logic             enter_walk_s;

   // Final count of the current phase; an all-red phase entered as a walk phase runs long.
   always_comb begin
      dur_m1_s = CNT_W'(GREEN_TICKS - 32'd1);
      case (state_r)
         NS_G, EW_G: dur_m1_s = CNT_W'(GREEN_TICKS - 32'd1);
         NS_Y, EW_Y: dur_m1_s = CNT_W'(YELLOW_TICKS - 32'd1);
         AR1, AR2: begin
            if (walk_r) dur_m1_s = CNT_W'(PED_TICKS - 32'd1);
            else        dur_m1_s = CNT_W'(ALLRED_TICKS - 32'd1);
         end
         default:    dur_m1_s = CNT_W'(GREEN_TICKS - 32'd1);
      endcase
   end

   // Phase-boundary events derived from the counter and current state.
   always_comb begin
      last_tick_s  = 1'b0;
      enter_ar_s   = 1'b0;
      leave_ar_s   = 1'b0;
      enter_walk_s = 1'b0;
      if (tick && (cnt_r == dur_m1_s)) begin
         last_tick_s  = 1'b1;
         enter_ar_s   = (state_r == NS_Y) || (state_r == EW_Y);
         leave_ar_s   = (state_r == AR1) || (state_r == AR2);
         enter_walk_s = enter_ar_s && (ped_pend_r || ped_req);
      end else begin
         last_tick_s  = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= NS_G;
      else     state_r <= state_nxt_s;
   end

   // Next-state: advance around the fixed ring on the last tick of a phase.
   always_comb begin
      state_nxt_s = state_r;
      if (last_tick_s) begin
         case (state_r)
            NS_G:    state_nxt_s = NS_Y;
            NS_Y:    state_nxt_s = AR1;
            AR1:     state_nxt_s = EW_G;
            EW_G:    state_nxt_s = EW_Y;
            EW_Y:    state_nxt_s = AR2;
            AR2:     state_nxt_s = NS_G;
            default: state_nxt_s = NS_G;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Tick counter plus pedestrian latch; a request on the walk-entry cycle is absorbed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r      <= '0;
         ped_pend_r <= 1'b0;
         walk_r     <= 1'b0;
      end else begin
         if (last_tick_s)  cnt_r <= '0;
         else if (tick)    cnt_r <= cnt_r + CNT_W'(1);

         if (enter_walk_s) ped_pend_r <= 1'b0;
         else if (ped_req) ped_pend_r <= 1'b1;

         if (enter_walk_s)    walk_r <= 1'b1;
         else if (leave_ar_s) walk_r <= 1'b0;
      end
   end

   // Moore lamp decode from the state register.
   always_comb begin
      ns_g = 1'b0;
      ns_y = 1'b0;
      ns_r = 1'b0;
      ew_g = 1'b0;
      ew_y = 1'b0;
      ew_r = 1'b0;
      case (state_r)
         NS_G:    begin ns_g = 1'b1; ew_r = 1'b1; end
         NS_Y:    begin ns_y = 1'b1; ew_r = 1'b1; end
         EW_G:    begin ns_r = 1'b1; ew_g = 1'b1; end
         EW_Y:    begin ns_r = 1'b1; ew_y = 1'b1; end
         AR1, AR2: begin ns_r = 1'b1; ew_r = 1'b1; end
         default: begin ns_r = 1'b1; ew_r = 1'b1; end
      endcase
      walk  = walk_r;
      phase = state_r;
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: hand-computed phase and lamp
// expectations checked with immediate assertions at each step.
module tb_traffic_light_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       ped_req = 1'b0;
   logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk;
   logic [2:0] phase;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected phase codes
   localparam logic [2:0] P_NSG = 3'd0, P_NSY = 3'd1, P_AR1 = 3'd2,
                          P_EWG = 3'd3, P_EWY = 3'd4, P_AR2 = 3'd5;
   // Lamps packed as {ns_g,ns_y,ns_r,ew_g,ew_y,ew_r,walk}
   localparam logic [6:0] L_NSG = 7'b1000010, L_NSY = 7'b0100010,
                          L_AR  = 7'b0010010, L_ARW = 7'b0010011,
                          L_EWG = 7'b0011000, L_EWY = 7'b0010100;

   traffic_light_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .ped_req (ped_req),
      .ns_g    (ns_g),
      .ns_y    (ns_y),
      .ns_r    (ns_r),
      .ew_g    (ew_g),
      .ew_y    (ew_y),
      .ew_r    (ew_r),
      .walk    (walk),
      .phase   (phase)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [2:0] ep, input logic [6:0] el);
      logic [6:0] lamps;
      lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};
      n_checks++;
      assert (phase === ep && lamps === el)
      else begin
         n_fail++;
         $error("FAIL %s: phase=%0d lamps=%b expected phase=%0d lamps=%b",
                tag, phase, lamps, ep, el);
      end
   endtask

   // n ticks spaced 4 clocks apart; returns at a falling edge after the last one took effect
   task automatic ticks(input int n, input logic ped_on_last = 1'b0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick = 1'b1;
         if (i == n - 1) ped_req = ped_on_last;
         @(negedge clk);
         tick = 1'b0;
         ped_req = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      tick = 1'b0;
      ped_req = 1'b0;
      #1;
      chk("reset_immediate", P_NSG, L_NSG);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [2:0] cont_phase(input int k);
      int m;
      m = k % 16;
      if (m < 5)       return P_NSG;
      else if (m < 7)  return P_NSY;
      else if (m < 8)  return P_AR1;
      else if (m < 13) return P_EWG;
      else if (m < 15) return P_EWY;
      else             return P_AR2;
   endfunction

   function automatic logic [6:0] cont_lamps(input logic [2:0] p);
      case (p)
         P_NSG:   return L_NSG;
         P_NSY:   return L_NSY;
         P_EWG:   return L_EWG;
         P_EWY:   return L_EWY;
         default: return L_AR;
      endcase
   endfunction

   initial begin
      // Reset state and 5-tick green with gap cycles
      #2;
      chk("reset_state", P_NSG, L_NSG);
      @(negedge clk);
      rst = 1'b0;
      chk("after_release", P_NSG, L_NSG);
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk);
         tick = 1'b1;
         chk("nsg_tick_high", P_NSG, L_NSG);
         @(negedge clk);
         tick = 1'b0;
         chk("nsg_after_tick", P_NSG, L_NSG);
         repeat (2) @(negedge clk);
         chk("nsg_gap", P_NSG, L_NSG);
      end
      ticks(1);
      chk("tick5_nsy", P_NSY, L_NSY);

      // Full cycle, no pedestrian
      do_reset();
      ticks(4); chk("seq_nsg4", P_NSG, L_NSG);
      ticks(1); chk("seq_nsy0", P_NSY, L_NSY);
      ticks(1); chk("seq_nsy1", P_NSY, L_NSY);
      ticks(1); chk("seq_ar1",  P_AR1, L_AR);
      ticks(1); chk("seq_ewg0", P_EWG, L_EWG);
      ticks(4); chk("seq_ewg4", P_EWG, L_EWG);
      ticks(1); chk("seq_ewy0", P_EWY, L_EWY);
      ticks(1); chk("seq_ewy1", P_EWY, L_EWY);
      ticks(1); chk("seq_ar2",  P_AR2, L_AR);
      ticks(1); chk("seq_wrap", P_NSG, L_NSG);

      // Pedestrian pulse during NS_G
      do_reset();
      ticks(2);
      @(negedge clk); ped_req = 1'b1;
      @(negedge clk); ped_req = 1'b0;
      ticks(3); chk("ped_nsy",      P_NSY, L_NSY);
      ticks(2); chk("ped_ar1_walk", P_AR1, L_ARW);
      ticks(1); chk("ped_ar1_t2",   P_AR1, L_ARW);
      ticks(1); chk("ped_ar1_t3",   P_AR1, L_ARW);
      ticks(1); chk("ped_ewg",      P_EWG, L_EWG);
      ticks(5); chk("ped_ewy",      P_EWY, L_EWY);
      ticks(2); chk("ped_ar2_norm", P_AR2, L_AR);
      ticks(1); chk("ped_back_nsg", P_NSG, L_NSG);

      // Request coincident with the tick that ends NS_Y
      do_reset();
      ticks(5); chk("same_nsy",  P_NSY, L_NSY);
      ticks(1);
      ticks(1, 1'b1); chk("same_ar1_walk", P_AR1, L_ARW);
      ticks(2); chk("same_ar1_t3",   P_AR1, L_ARW);
      ticks(1); chk("same_ewg",      P_EWG, L_EWG);
      ticks(7); chk("same_ar2_norm", P_AR2, L_AR);
      ticks(1); chk("same_nsg",      P_NSG, L_NSG);

      // Request during a walk phase carries over to the next all-red
      do_reset();
      ticks(7, 1'b1); chk("carry_ar1", P_AR1, L_ARW);
      @(negedge clk); ped_req = 1'b1;
      @(negedge clk); ped_req = 1'b0;
      ticks(3); chk("carry_ewg",     P_EWG, L_EWG);
      ticks(7); chk("carry_ar2",     P_AR2, L_ARW);
      ticks(2); chk("carry_ar2_t3",  P_AR2, L_ARW);
      ticks(1); chk("carry_nsg",     P_NSG, L_NSG);

      // Async reset during EW_Y, then a full green is needed
      do_reset();
      ticks(14); chk("mid_ewy", P_EWY, L_EWY);
      do_reset();
      ticks(4); chk("rst_nsg4", P_NSG, L_NSG);
      ticks(1); chk("rst_nsy",  P_NSY, L_NSY);

      // Tick held high continuously
      do_reset();
      @(negedge clk);
      tick = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         chk($sformatf("cont_k%0d", k), cont_phase(k), cont_lamps(cont_phase(k)));
      end
      tick = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
